// File: rtl/tt_ovi_pkg.sv
// Shared OVI completion-stage widths, the completion record type and its packing helper.
package tt_ovi_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int SB_ID_W   = 5;
  localparam int DATA_W    = 64;
  localparam int FFLAGS_W  = 5;
  localparam int VSTART_W  = 14;

  typedef struct packed {
    logic [SB_ID_W-1:0]  sb_id;
    logic [FFLAGS_W-1:0] fflags;
    logic                vxsat;
    logic [DATA_W-1:0]   dest_reg;
  } ovi_cmpl_t;

  function automatic ovi_cmpl_t make_cmpl(input logic [SB_ID_W-1:0]  sb_id,
                                          input logic [FFLAGS_W-1:0] fflags,
                                          input logic                vxsat,
                                          input logic [DATA_W-1:0]   dest_reg);
    ovi_cmpl_t c;
    c.sb_id    = sb_id;
    c.fflags   = fflags;
    c.vxsat    = vxsat;
    c.dest_reg = dest_reg;
    return c;
  endfunction

endpackage

// File: rtl/tt_ovi_completion_tracker_if.sv
// Hand-off, commit and completion bundle between the OVI wrapper and the completion tracker.
interface tt_ovi_completion_tracker_if #(
  parameter int DEPTH   = tt_ovi_pkg::DEF_DEPTH,
  parameter int SB_ID_W = tt_ovi_pkg::SB_ID_W,
  parameter int DATA_W  = tt_ovi_pkg::DATA_W
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                          accept_valid;
  logic [SB_ID_W-1:0]            accept_sb_id;
  logic                          accept_ready;
  logic                          commit_valid;
  logic [DATA_W-1:0]             commit_data;
  logic [tt_ovi_pkg::FFLAGS_W-1:0] commit_fflags;
  logic                          commit_vxsat;
  logic                          flush;
  logic                          completed_valid;
  logic [SB_ID_W-1:0]            completed_sb_id;
  logic [tt_ovi_pkg::FFLAGS_W-1:0] completed_fflags;
  logic [DATA_W-1:0]             completed_dest_reg;
  logic                          completed_vxsat;
  logic [tt_ovi_pkg::VSTART_W-1:0] completed_vstart;
  logic                          completed_illegal;
  logic                          issue_credit;
  logic [CNT_W-1:0]              inflight_cnt;
  logic                          err_underflow;

  modport master (
    output accept_valid, accept_sb_id, commit_valid, commit_data, commit_fflags,
           commit_vxsat, flush,
    input  accept_ready, completed_valid, completed_sb_id, completed_fflags,
           completed_dest_reg, completed_vxsat, completed_vstart, completed_illegal,
           issue_credit, inflight_cnt, err_underflow
  );

  modport slave (
    input  accept_valid, accept_sb_id, commit_valid, commit_data, commit_fflags,
           commit_vxsat, flush,
    output accept_ready, completed_valid, completed_sb_id, completed_fflags,
           completed_dest_reg, completed_vxsat, completed_vstart, completed_illegal,
           issue_credit, inflight_cnt, err_underflow
  );

endinterface

// File: rtl/tt_ovi_tag_fifo.sv
// In-order sb_id store: push on hand-off, pop on commit, flush empties by snapping rd to wr.
module tt_ovi_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify events; a push into a full store is kept only when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s  = pop & ~flush & (cnt_r != {CNT_W{1'b0}});
    push_ok_s = push & ~flush & ((cnt_r != CNT_W'(DEPTH)) | pop_ok_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (cnt_r == CNT_W'(DEPTH));
  assign empty = (cnt_r == {CNT_W{1'b0}});
  assign cnt   = cnt_r;

endmodule

// File: rtl/tt_ovi_completion_tracker.sv
// OVI completion stage: pairs each pipeline commit with the oldest outstanding sb_id and
// returns a registered completion plus one issue credit.
module tt_ovi_completion_tracker #(
  parameter int DEPTH   = tt_ovi_pkg::DEF_DEPTH,
  parameter int SB_ID_W = tt_ovi_pkg::SB_ID_W,
  parameter int DATA_W  = tt_ovi_pkg::DATA_W
) (
  input logic                        clk,
  input logic                        reset_n,
  tt_ovi_completion_tracker_if.slave bus
);
  import tt_ovi_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SB_ID_W-1:0] head_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               pop_ok_s;
  logic               underflow_s;
  ovi_cmpl_t          cmpl_r;
  logic               valid_r;
  logic               credit_r;
  logic               err_r;

  tt_ovi_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (SB_ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.accept_valid),
    .pop     (bus.commit_valid),
    .flush   (bus.flush),
    .din     (bus.accept_sb_id),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .cnt     (cnt_s)
  );

  // A commit only completes against a tag already stored; kill suppresses both outcomes.
  always_comb begin
    pop_ok_s    = bus.commit_valid & ~bus.flush & ~empty_s;
    underflow_s = bus.commit_valid & ~bus.flush & empty_s;
  end

  // Completion record, valid/credit pulses and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmpl_r   <= '0;
      valid_r  <= 1'b0;
      credit_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      valid_r  <= pop_ok_s;
      credit_r <= pop_ok_s;
      if (pop_ok_s) begin
        cmpl_r <= make_cmpl(head_s, bus.commit_fflags, bus.commit_vxsat, bus.commit_data);
      end
      if (underflow_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.accept_ready       = ~full_s;
  assign bus.inflight_cnt       = cnt_s;
  assign bus.completed_valid    = valid_r;
  assign bus.issue_credit       = credit_r;
  assign bus.completed_sb_id    = cmpl_r.sb_id;
  assign bus.completed_fflags   = cmpl_r.fflags;
  assign bus.completed_vxsat    = cmpl_r.vxsat;
  assign bus.completed_dest_reg = cmpl_r.dest_reg;
  assign bus.completed_vstart   = {VSTART_W{1'b0}};
  assign bus.completed_illegal  = 1'b0;
  assign bus.err_underflow      = err_r;

endmodule
